// File: rtl/regfile_write_port.sv
// regfile_write_port: 32 x 32-bit register file write side, with a 2-entry
// in-order request FIFO that retires one write per cycle under commit_en.
// Optional build macro: REG0_ZERO_EN makes register 0 read as constant zero.
// Requests to address 0 still retire and still pulse commit_valid.
module regfile_write_port (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [4:0]    wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          commit_en,
    output logic [1023:0] regs_flat,
    output logic          commit_valid,
    output logic [4:0]    commit_addr,
    output logic [1:0]    pending
);

    logic [4:0]  fifo_addr_q [2];
    logic [4:0]  fifo_addr_d [2];
    logic [31:0] fifo_data_q [2];
    logic [31:0] fifo_data_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        commit_valid_q, commit_valid_d;
    logic [4:0]  commit_addr_q, commit_addr_d;

    logic        push;
    logic        pop;
    logic [4:0]  head_addr;
    logic [31:0] head_data;
    logic [31:0] wr_sel;

    // Ready comes from registered occupancy only, so commit_en has no path to it.
    always_comb begin
        wr_ready  = rst_n && (count_q != 2'd2);
        push      = wr_valid && wr_ready;
        pop       = (count_q != 2'd0) && commit_en;
        head_addr = fifo_addr_q[rd_ptr_q];
        head_data = fifo_data_q[rd_ptr_q];
    end

    // FIFO next state: push at write pointer, pop at read pointer, both wrap mod 2.
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = wr_addr;
            fifo_data_d[wr_ptr_q] = wr_data;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // One-hot decode of the retiring head address; at most one register updates.
    always_comb begin
        wr_sel = '0;
        if (pop) begin
            wr_sel[head_addr] = 1'b1;
        end
        for (int unsigned i = 0; i < 32; i++) begin
            regs_d[i] = wr_sel[i] ? head_data : regs_q[i];
        end
`ifdef REG0_ZERO_EN
        regs_d[0] = '0;
`else
`endif
        commit_valid_d = pop;
        commit_addr_d  = pop ? head_addr : commit_addr_q;
    end

    // State registers with synchronous active-low reset; reset drops buffered requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_addr_q  <= '0;
        end else begin
            fifo_addr_q    <= fifo_addr_d;
            fifo_data_q    <= fifo_data_d;
            regs_q         <= regs_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_addr_q  <= commit_addr_d;
        end
    end

    // Flatten the register array for the read mux and drive the status outputs.
    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            regs_flat[32*i +: 32] = regs_q[i];
        end
        commit_valid = commit_valid_q;
        commit_addr  = commit_addr_q;
        pending      = count_q;
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed self-checking bench for regfile_write_port.
// Honours REG0_ZERO_EN when the macro is defined for the build.
module tb_regfile_write_port;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          commit_en;
    logic [1023:0] regs_flat;
    logic          commit_valid;
    logic [4:0]    commit_addr;
    logic [1:0]    pending;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [1023:0] exp_regs;

    regfile_write_port dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit_en    (commit_en),
        .regs_flat    (regs_flat),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        commit_en = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_pending", 1024'(pending), 1024'(2'd0));
        check("rst_cvalid", 1024'(commit_valid), 1024'(1'b0));
        check("rst_caddr", 1024'(commit_addr), 1024'(5'd0));
        check("rst_regs", regs_flat, '0);
        check("rst_ready", 1024'(wr_ready), 1024'(1'b0));
        rst_n = 1'b1;
        #1;
        check("ready_after_release", 1024'(wr_ready), 1024'(1'b1));

        // Single write 5 <- DEADBEEF
        wr_valid  = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 32'hDEADBEEF;
        commit_en = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("single_pending_n", 1024'(pending), 1024'(2'd1));
        check("single_cvalid_n", 1024'(commit_valid), 1024'(1'b0));
        tick();
        exp_regs = '0;
        exp_regs[191:160] = 32'hDEADBEEF;
        check("single_regs", regs_flat, exp_regs);
        check("single_cvalid", 1024'(commit_valid), 1024'(1'b1));
        check("single_caddr", 1024'(commit_addr), 1024'(5'd5));
        check("single_pending", 1024'(pending), 1024'(2'd0));
        tick();
        check("single_pulse_end", 1024'(commit_valid), 1024'(1'b0));

        // Backpressure: three requests with commit disabled
        commit_en = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 5'd1;
        wr_data   = 32'h0000_0101;
        tick();
        check("bp_pending1", 1024'(pending), 1024'(2'd1));
        check("bp_ready1", 1024'(wr_ready), 1024'(1'b1));
        wr_addr = 5'd2;
        wr_data = 32'h0000_0202;
        tick();
        check("bp_pending2", 1024'(pending), 1024'(2'd2));
        check("bp_ready_full", 1024'(wr_ready), 1024'(1'b0));
        wr_addr = 5'd3;
        wr_data = 32'h0000_0303;
        tick();
        check("bp_held_pending", 1024'(pending), 1024'(2'd2));
        check("bp_held_ready", 1024'(wr_ready), 1024'(1'b0));
        check("bp_no_commit", 1024'(commit_valid), 1024'(1'b0));
        // Full with a pop: request 3 is not taken at this edge
        commit_en = 1'b1;
        check("bp_full_pop_ready", 1024'(wr_ready), 1024'(1'b0));
        tick();
        check("bp_ret1_cvalid", 1024'(commit_valid), 1024'(1'b1));
        check("bp_ret1_caddr", 1024'(commit_addr), 1024'(5'd1));
        check("bp_ret1_pending", 1024'(pending), 1024'(2'd1));
        check("bp_ret1_reg", 1024'(regs_flat[63:32]), 1024'(32'h0000_0101));
        check("bp_ret1_ready", 1024'(wr_ready), 1024'(1'b1));
        // Push of 3 and pop of 2 at the same edge
        tick();
        wr_valid = 1'b0;
        check("bp_ret2_caddr", 1024'(commit_addr), 1024'(5'd2));
        check("bp_ret2_pending", 1024'(pending), 1024'(2'd1));
        check("bp_ret2_reg", 1024'(regs_flat[95:64]), 1024'(32'h0000_0202));
        tick();
        check("bp_ret3_cvalid", 1024'(commit_valid), 1024'(1'b1));
        check("bp_ret3_caddr", 1024'(commit_addr), 1024'(5'd3));
        check("bp_ret3_pending", 1024'(pending), 1024'(2'd0));
        exp_regs[63:32]  = 32'h0000_0101;
        exp_regs[95:64]  = 32'h0000_0202;
        exp_regs[127:96] = 32'h0000_0303;
        check("bp_regs_all", regs_flat, exp_regs);
        tick();
        check("bp_drained_cvalid", 1024'(commit_valid), 1024'(1'b0));

        // Same address twice: last accepted wins
        commit_en = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 5'd7;
        wr_data   = 32'h11;
        tick();
        wr_data = 32'h22;
        tick();
        wr_valid  = 1'b0;
        commit_en = 1'b1;
        tick();
        check("same_first_cvalid", 1024'(commit_valid), 1024'(1'b1));
        check("same_first_reg", 1024'(regs_flat[255:224]), 1024'(32'h11));
        tick();
        check("same_second_cvalid", 1024'(commit_valid), 1024'(1'b1));
        check("same_second_caddr", 1024'(commit_addr), 1024'(5'd7));
        tick();
        check("same_end_cvalid", 1024'(commit_valid), 1024'(1'b0));
        check("same_end_reg", 1024'(regs_flat[255:224]), 1024'(32'h22));

        // Reset with two buffered requests and a handshake attempt at the reset edge
        commit_en = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 5'd9;
        wr_data   = 32'hAA;
        tick();
        wr_addr = 5'd10;
        wr_data = 32'hBB;
        tick();
        check("mid_pending2", 1024'(pending), 1024'(2'd2));
        rst_n     = 1'b0;
        commit_en = 1'b1;
        wr_addr   = 5'd12;
        wr_data   = 32'hCC;
        tick();
        check("mid_rst_pending", 1024'(pending), 1024'(2'd0));
        check("mid_rst_regs", regs_flat, '0);
        check("mid_rst_cvalid", 1024'(commit_valid), 1024'(1'b0));
        check("mid_rst_caddr", 1024'(commit_addr), 1024'(5'd0));
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        tick();
        check("mid_after_cvalid", 1024'(commit_valid), 1024'(1'b0));
        check("mid_after_pending", 1024'(pending), 1024'(2'd0));
        check("mid_after_regs", regs_flat, '0);

        // Register 0 write
        wr_valid = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'hFFFF_FFFF;
        tick();
        wr_valid = 1'b0;
        tick();
        check("r0_cvalid", 1024'(commit_valid), 1024'(1'b1));
        check("r0_caddr", 1024'(commit_addr), 1024'(5'd0));
`ifdef REG0_ZERO_EN
        check("r0_value", 1024'(regs_flat[31:0]), 1024'(32'h0));
`else
        check("r0_value", 1024'(regs_flat[31:0]), 1024'(32'hFFFF_FFFF));
`endif
        check("r0_others", 1024'(regs_flat[1023:32]), '0);
        tick();

        // Full-throughput sweep: i <- i * 0x01010101
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 5'(i);
            wr_data  = 32'(i) * 32'h0101_0101;
            check("sweep_ready", 1024'(wr_ready), 1024'(1'b1));
            tick();
        end
        wr_valid = 1'b0;
        tick();
        check("sweep_pending", 1024'(pending), 1024'(2'd0));
        for (int i = 0; i < 32; i++) begin
            check($sformatf("sweep_slice%0d", i), 1024'(regs_flat[32*i +: 32]),
                  1024'(32'(i) * 32'h0101_0101));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
